// File: rtl/scan_ctrl.sv
// rtl/scan_ctrl.sv - scan test sequencer: serial load, single capture clock, unload and masked compare
module scan_ctrl #(
    parameter int CHAIN_LEN = 3
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] vector_in,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] care_mask,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] vec_q, vec_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] mask_q, mask_d;
    logic [CHAIN_LEN-1:0] cap_q, cap_d;
    logic                 pass_q, pass_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_in_q, scan_in_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            vec_q     <= '0;
            exp_q     <= '0;
            mask_q    <= '0;
            cap_q     <= '0;
            pass_q    <= 1'b0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec_q     <= vec_d;
            exp_q     <= exp_d;
            mask_q    <= mask_d;
            cap_q     <= cap_d;
            pass_q    <= pass_d;
            scan_en_q <= scan_en_d;
            scan_in_q <= scan_in_d;
        end
    end

    // scan_en/scan_in are computed one cycle ahead so they come straight from flops.
    // vec_q is kept pre-shifted: its MSB is always the next bit to present on scan_in.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        exp_d     = exp_q;
        mask_d    = mask_q;
        cap_d     = cap_q;
        pass_d    = pass_q;
        scan_en_d = 1'b0;
        scan_in_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    vec_d     = vector_in << 1;
                    exp_d     = expected;
                    mask_d    = care_mask;
                    cap_d     = '0;
                    pass_d    = 1'b0;
                    scan_en_d = 1'b1;
                    scan_in_d = vector_in[CHAIN_LEN-1];
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    scan_en_d = 1'b1;
                    scan_in_d = vec_q[CHAIN_LEN-1];
                    vec_d     = vec_q << 1;
                end
            end
            CAPTURE: begin
                state_d   = UNLOAD;
                cnt_d     = '0;
                scan_en_d = 1'b1;
            end
            UNLOAD: begin
                cap_d = (cap_q << 1) | CHAIN_LEN'(scan_out);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    pass_d  = ((cap_d ^ exp_q) & mask_q) == '0;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    scan_en_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign scan_en  = scan_en_q;
    assign scan_in  = scan_in_q;
    assign busy     = (state_q == SHIFT) || (state_q == CAPTURE) || (state_q == UNLOAD);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign captured = cap_q;

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 3, giving the number of flops in the target scan chain (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 The block SHALL have port n_reset, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request to run one scan test.
REQ-005 The block SHALL have port vector_in, input, CHAIN_LEN bits: the stimulus to load into the chain.
REQ-006 The block SHALL have port expected, input, CHAIN_LEN bits: the golden capture response.
REQ-007 The block SHALL have port care_mask, input, CHAIN_LEN bits: a 1 marks a response bit that is compared.
REQ-008 The block SHALL have port scan_out, input, 1 bit: the serial output of the last flop in the chain (the chain's O).
REQ-009 The block SHALL have port scan_en, output, 1 bit: the chain mode select (the chain's M); 1 = shift.
REQ-010 The block SHALL have port scan_in, output, 1 bit: serial data into the first flop of the chain (the chain's I).
REQ-011 The block SHALL have port busy, done and pass outputs, 1 bit each, and port captured, output, CHAIN_LEN bits.

Function
REQ-012 The FSM SHALL have exactly five states: IDLE, SHIFT, CAPTURE, UNLOAD and DONE.
REQ-013 In IDLE, start=1 SHALL be accepted on the next edge:
- inputs vector_in, expected and care_mask are latched internally;
- the FSM moves to SHIFT;
- the bit counter clears.
REQ-014 start SHALL be ignored in every state other than IDLE; later changes to vector_in, expected and care_mask SHALL have no effect on a test in progress.
REQ-015 SHIFT SHALL last CHAIN_LEN cycles:
- scan_en=1;
- scan_in = latched vector bit CHAIN_LEN-1-k on shift cycle k (k = 0..CHAIN_LEN-1), MSB first;
- after SHIFT, chain flop i holds vector_in[i], where flop 0 is fed by scan_in and flop CHAIN_LEN-1 drives scan_out.
REQ-016 CAPTURE SHALL last exactly 1 cycle with scan_en=0 and scan_in=0, so that one functional clock captures the next state into the chain.
REQ-017 UNLOAD SHALL last CHAIN_LEN cycles:
- scan_en=1 and scan_in=0;
- on each edge in UNLOAD, scan_out is sampled before the chain shift takes effect;
- captured shifts left with the sampled bit entering bit 0, so the first sampled bit ends in captured[CHAIN_LEN-1] and captured[i] equals the value captured by chain flop i.
REQ-018 DONE SHALL last exactly 1 cycle:
- done=1;
- pass=1 if and only if ((captured XOR expected) AND care_mask) == 0;
- the FSM then returns to IDLE.
REQ-019 Latency SHALL be as follows, with start sampled at edge e0:
- SHIFT occupies e0..eN;
- the CAPTURE edge is e(N+1);
- the UNLOAD edges are e(N+2)..e(2N+1);
- done is high between e(2N+1) and e(2N+2), where N = CHAIN_LEN;
- the total is 2N+2 cycles from start to done.
REQ-020 busy SHALL be 1 in SHIFT, CAPTURE and UNLOAD, and 0 in IDLE and DONE.
REQ-021 Holding values:
- pass and captured SHALL hold their values from DONE until the next accepted start;
- pass SHALL clear to 0 on acceptance;
- captured SHALL clear to 0 on acceptance.
REQ-022 scan_en and scan_in SHALL be driven directly from flops, with no combinational path from start or scan_out to either output.
REQ-023 care_mask = 0 SHALL yield pass=1 regardless of the captured value.
REQ-024 The bit counter SHALL be ceil(log2(CHAIN_LEN+1)) bits wide and SHALL never wrap within a state.
REQ-025 For CHAIN_LEN=1, SHIFT and UNLOAD SHALL each last 1 cycle.

Reset
REQ-026 While n_reset=0, regardless of the clock:
- the FSM is in IDLE;
- scan_en=0, scan_in=0;
- busy=0, done=0, pass=0;
- captured=0;
- the counter is 0;
- all latched inputs are 0.
REQ-027 A reset asserted mid-test SHALL abort the test immediately, with no done pulse.
REQ-028 After reset deasserts, the first start SHALL be accepted normally.

Verification
REQ-029 The bench SHALL cover the following directed scenarios, using CHAIN_LEN=3 and a behavioural 3-flop chain model that captures the fixed value 3'b110.
- Nominal: vector_in=3'b101, expected=3'b110, care_mask=3'b111 -> scan_in sequence 1,0,1; scan_en low exactly 1 cycle; done at cycle 8 after start; captured=3'b110; pass=1.
- Mismatch: expected=3'b100, care_mask=3'b111 -> pass=0, captured=3'b110; with care_mask=3'b101 -> pass=1.
- Ignored start: start pulsed every cycle during a test -> exactly one done; the next test starts only after IDLE is re-entered.
- Reset mid-UNLOAD: n_reset low at cycle 6 -> scan_en=0, busy=0, captured=0 immediately; no done; a fresh test then passes.
- Loopback: scan_out tied to a 3-flop shift register with no capture, vector_in=3'b011 -> captured=3'b011.
- CHAIN_LEN=1: vector_in=1, chain model captures 0, expected=0 -> done 4 cycles after start, pass=1.
